sa_input_feeder: RTL and testbench

SA_INPUT_FEEDER -- requirements
Module: sa_input_feeder

---
 rtl/sa_pkg.sv | 14 +
 rtl/sa_skew_lane.sv | 32 +++
 rtl/sa_input_feeder.sv | 118 +++++++++++
 tb/tb_sa_input_feeder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types for the systolic-array input feeder.
// Holds the activation width default and the feeder FSM state enum.
package sa_pkg;

  localparam int DWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } feed_state_t;

endpackage

// File: rtl/sa_skew_lane.sv
// Enable-shifted DEPTH-stage register chain for one feeder lane.
// Ports: clk, rstn, en (shift), clr (sync zero), d (chain in), q (last stage).
module sa_skew_lane #(
  parameter int DEPTH  = 1,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              clr,
  input  logic [DWIDTH-1:0] d,
  output logic [DWIDTH-1:0] q
);

  logic [DEPTH-1:0][DWIDTH-1:0] r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r <= '0;
    end else if (clr) begin
      r <= '0;
    end else if (en) begin
      r[0] <= d;
      for (int j = 1; j < DEPTH; j++) begin
        r[j] <= r[j-1];
      end
    end
  end

  assign q = r[DEPTH-1];

endmodule

// File: rtl/sa_input_feeder.sv
// Skews activation beats into a ROWS-row systolic array and drains the tail.
// Ports: clk, rstn, start/k_len/abort control, in_* beat handshake, out_a/fire/busy/done.
module sa_input_feeder
  import sa_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int KW     = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   abort,
  input  logic [ROWS*DWIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ROWS*DWIDTH-1:0] out_a,
  output logic                   fire,
  output logic                   busy,
  output logic                   done
);

  localparam int DCW = (ROWS > 2) ? $clog2(ROWS) : 1;

  feed_state_t    state;
  feed_state_t    state_nx;
  logic [KW-1:0]  k_reg;
  logic [KW-1:0]  beat_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           accept;
  logic           advance;
  logic           last_beat;
  logic           drain_last;

  assign in_ready   = (state == STREAM);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign accept     = in_ready && in_valid;
  assign advance    = accept || (state == DRAIN);
  assign last_beat  = (beat_cnt == k_reg - KW'(1));
  assign drain_last = (drain_cnt == DCW'(ROWS - 2));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (k_len == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (accept && last_beat) begin
          state_nx = (ROWS == 1) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (abort) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      fire      <= 1'b0;
    end else begin
      state <= state_nx;
      fire  <= advance && !abort;
      if (abort) begin
        beat_cnt  <= '0;
        drain_cnt <= '0;
      end else begin
        if (state == IDLE && start) begin
          k_reg    <= k_len;
          beat_cnt <= '0;
        end else if (accept) begin
          beat_cnt <= beat_cnt + KW'(1);
        end
        if (state == DRAIN) begin
          drain_cnt <= drain_last ? '0 : drain_cnt + DCW'(1);
        end
      end
    end
  end

  // Zeros are pushed into every lane while draining the tail.
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [DWIDTH-1:0] lane_in;
    assign lane_in = (state == DRAIN) ? '0 : in_data[i*DWIDTH +: DWIDTH];
    sa_skew_lane #(
      .DEPTH (i + 1),
      .DWIDTH(DWIDTH)
    ) u_lane (
      .clk (clk),
      .rstn(rstn),
      .en  (advance),
      .clr (abort),
      .d   (lane_in),
      .q   (out_a[i*DWIDTH +: DWIDTH])
    );
  end

endmodule

// File: tb/tb_sa_input_feeder.sv
// Directed self-checking bench for sa_input_feeder (ROWS=4, DWIDTH=8).
// Records every fire beat and done pulse, then compares against hand values.
module tb_sa_input_feeder;

  localparam int ROWS   = 4;
  localparam int DWIDTH = 8;
  localparam int KW     = 8;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   abort;
  logic [ROWS*DWIDTH-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DWIDTH-1:0] out_a;
  logic                   fire;
  logic                   busy;
  logic                   done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [31:0] fq[$];

  logic [31:0] exp_skew[5] = '{32'h00000001, 32'h00000205, 32'h00030600,
                               32'h04070000, 32'h08000000};
  logic [31:0] exp_stall[6] = '{32'h00000011, 32'h00001221, 32'h00132231,
                                32'h14233200, 32'h24330000, 32'h34000000};
  logic [31:0] exp_k1[4] = '{32'h00000011, 32'h00002200, 32'h00330000,
                             32'h44000000};

  always #5 clk = ~clk;

  sa_input_feeder #(
    .ROWS  (ROWS),
    .DWIDTH(DWIDTH),
    .KW    (KW)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .k_len   (k_len),
    .abort   (abort),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_a   (out_a),
    .fire    (fire),
    .busy    (busy),
    .done    (done)
  );

  always @(negedge clk) begin
    if (rstn) begin
      if (fire) fq.push_back(out_a);
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cnt > d0), 32'd1);
    tick();
    tick();
  endtask

  task automatic chk_q(input string tag, input int idx,
                       input logic [31:0] exp);
    chk(tag, (idx < fq.size()) ? fq[idx] : 32'hdeadbeef, exp);
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    k_len = '0;
    abort = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_out_a", out_a, 32'h0);
    chk("rst_fire", 32'(fire), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    tick();

    // skew: two beats, latched length unaffected by later k_len
    fq.delete();
    done_cnt = 0;
    start = 1'b1;
    k_len = 8'd2;
    tick();
    start = 1'b0;
    k_len = 8'd7;
    chk("skew_ready", 32'(in_ready), 32'd1);
    chk("skew_busy", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_data = 32'h04030201;
    tick();
    in_data = 32'h08070605;
    tick();
    in_valid = 1'b0;
    chk("skew_ready_off", 32'(in_ready), 32'd0);
    wait_done(20);
    chk("skew_nfire", 32'(fq.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk_q("skew_beat", i, exp_skew[i]);
    chk("skew_ndone", 32'(done_cnt), 32'd1);
    chk("skew_idle", 32'(busy), 32'd0);

    // stall: two idle cycles between beat 1 and beat 2
    fq.delete();
    done_cnt = 0;
    start = 1'b1;
    k_len = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h14131211;
    tick();
    in_valid = 1'b0;
    tick();
    chk("stall1_fire", 32'(fire), 32'd0);
    chk("stall1_hold", out_a, 32'h00000011);
    tick();
    chk("stall2_fire", 32'(fire), 32'd0);
    chk("stall2_hold", out_a, 32'h00000011);
    in_valid = 1'b1;
    in_data = 32'h24232221;
    tick();
    in_data = 32'h34333231;
    tick();
    in_valid = 1'b0;
    wait_done(20);
    chk("stall_nfire", 32'(fq.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk_q("stall_beat", i, exp_stall[i]);

    // zero length
    fq.delete();
    done_cnt = 0;
    start = 1'b1;
    k_len = 8'd0;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_ready", 32'(in_ready), 32'd0);
    tick();
    chk("zero_done_off", 32'(done), 32'd0);
    chk("zero_busy_off", 32'(busy), 32'd0);
    tick();
    chk("zero_nfire", 32'(fq.size()), 32'd0);
    chk("zero_ndone", 32'(done_cnt), 32'd1);

    // abort during drain, then a clean k_len=1 tile
    done_cnt = 0;
    start = 1'b1;
    k_len = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'ha4a3a2a1;
    tick();
    in_data = 32'hb4b3b2b1;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_a", out_a, 32'h0);
    chk("abort_fire", 32'(fire), 32'd0);
    tick();
    tick();
    tick();
    chk("abort_ndone", 32'(done_cnt), 32'd0);
    fq.delete();
    start = 1'b1;
    k_len = 8'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h44332211;
    tick();
    in_valid = 1'b0;
    wait_done(20);
    chk("k1_nfire", 32'(fq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_q("k1_beat", i, exp_k1[i]);
    chk("k1_ndone", 32'(done_cnt), 32'd1);

    // start during STREAM is ignored
    fq.delete();
    done_cnt = 0;
    start = 1'b1;
    k_len = 8'd2;
    tick();
    in_valid = 1'b1;
    in_data = 32'h04030201;
    start = 1'b1;
    k_len = 8'd9;
    tick();
    start = 1'b0;
    in_data = 32'h08070605;
    tick();
    chk("ign_ready", 32'(in_ready), 32'd0);
    chk("ign_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_done(20);
    chk("ign_nfire", 32'(fq.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk_q("ign_beat", i, exp_skew[i]);

    // full-length tile: counter must not wrap
    fq.delete();
    done_cnt = 0;
    start = 1'b1;
    k_len = 8'd255;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h01010101;
    wait_done(400);
    in_valid = 1'b0;
    chk("max_nfire", 32'(fq.size()), 32'd258);
    chk("max_ndone", 32'(done_cnt), 32'd1);

    // reset mid-STREAM
    done_cnt = 0;
    start = 1'b1;
    k_len = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h55555555;
    tick();
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("mrst_out_a", out_a, 32'h0);
    chk("mrst_fire", 32'(fire), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) tick();
    chk("mrst_idle", 32'(busy), 32'd0);
    chk("mrst_ndone", 32'(done_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
